// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer around viterbi_decoder: clears the decoder, gates FRAME_LEN+TAIL_LEN
// symbol pairs in, forwards FRAME_LEN decoded bits out with a last marker, aborts on stall.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN  = 628,
  parameter int TAIL_LEN   = 20,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 11
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_data,
  output logic        dec_RSTn,
  output logic        dec_in_valid,
  output logic [1:0]  dec_in,
  input  logic        dec_out_valid,
  input  logic        dec_out,
  output logic        m_valid,
  output logic        m_data,
  output logic        m_last,
  output logic [15:0] frame_cnt
);

  localparam int TOTAL = FRAME_LEN + TAIL_LEN;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               clr_q, clr_d;
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               dec_in_valid_q, dec_in_valid_d;
  logic [1:0]         dec_in_q, dec_in_d;
  logic               m_valid_q, m_valid_d;
  logic               m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               err_q, err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               xfer;
  logic               fwd;
  logic               last_fwd;

  always_comb begin
    state_d        = state_q;
    clr_d          = 1'b0;
    clr_cnt_d      = clr_cnt_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    dec_in_valid_d = 1'b0;
    dec_in_d       = dec_in_q;
    m_valid_d      = 1'b0;
    m_data_d       = m_data_q;
    m_last_d       = 1'b0;
    err_d          = err_q;
    frame_cnt_d    = frame_cnt_q;

    xfer     = (state_q == S_FEED) && s_valid;
    fwd      = dec_out_valid && ((state_q == S_FEED) || (state_q == S_DRAIN))
               && (out_cnt_q < CNT_W'(FRAME_LEN));
    last_fwd = fwd && (out_cnt_q == CNT_W'(FRAME_LEN - 1));

    if (xfer) begin
      dec_in_valid_d = 1'b1;
      dec_in_d       = s_data;
      in_cnt_d       = in_cnt_q + CNT_W'(1);
    end

    // Surplus decoder output beyond FRAME_LEN bits is dropped here.
    if (fwd) begin
      m_valid_d = 1'b1;
      m_data_d  = dec_out;
      m_last_d  = last_fwd;
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          clr_d     = 1'b1;
          clr_cnt_d = '0;
          err_d     = 1'b0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_CLR: begin
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = S_FEED;
        end else begin
          clr_d     = 1'b1;
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      S_FEED: begin
        if (xfer && (in_cnt_q == CNT_W'(TOTAL - 1))) begin
          state_d   = S_DRAIN;
          tmo_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // Completion wins over a timeout landing on the same cycle.
        if (last_fwd || (out_cnt_q == CNT_W'(FRAME_LEN))) begin
          state_d = S_DONE;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q        <= S_IDLE;
      clr_q          <= 1'b0;
      clr_cnt_q      <= '0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      dec_in_valid_q <= 1'b0;
      dec_in_q       <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= 1'b0;
      m_last_q       <= 1'b0;
      err_q          <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      clr_q          <= clr_d;
      clr_cnt_q      <= clr_cnt_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      dec_in_valid_q <= dec_in_valid_d;
      dec_in_q       <= dec_in_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      err_q          <= err_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign s_ready      = (state_q == S_FEED);
  assign dec_RSTn     = RSTn & ~clr_q;
  assign dec_in_valid = dec_in_valid_q;
  assign dec_in       = dec_in_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign err_timeout  = err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed frame sequence with random symbols/gaps and a stand-in decoder that emits
// a configurable number of bits per frame; expectations come from frame-level rules.
module tb_viterbi_frame_ctrl;

  localparam int FRAME_LEN  = 628;
  localparam int TOTAL      = 648;
  localparam int CLR_CYCLES = 2;
  localparam int TMO        = 64;
  localparam int LAT        = 30;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_timeout;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_data = '0;
  logic        dec_RSTn, dec_in_valid;
  logic [1:0]  dec_in;
  logic        dec_out_valid = 1'b0;
  logic        dec_out = 1'b0;
  logic        m_valid, m_data, m_last;
  logic [15:0] frame_cnt;

  viterbi_frame_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .RSTn(RSTn), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dec_RSTn(dec_RSTn), .dec_in_valid(dec_in_valid), .dec_in(dec_in),
    .dec_out_valid(dec_out_valid), .dec_out(dec_out), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  // stand-in decoder state
  int rx = 0, emitted = 0, n_cfg = 0, n_act = 0;
  bit fwd_pend = 0, fwd_bit = 0, fwd_last = 0;
  // upstream / frame bookkeeping
  bit prev_xfer = 0;
  logic [1:0] prev_data = '0;
  int xfers = 0, t_last = 0, gap_mode = 0, pidx = 0;
  bit feeding = 0, start_req = 0, poke_done = 0;
  int mvalid_cnt = 0, mlast_cnt = 0, clr_low = 0, done_cnt = 0, done_cyc = 0;
  int exp_frames = 0;
  bit pat5 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit v;
    @(negedge clk);
    cyc++;
    if (RSTn) begin
      chk("dec_in_valid", {31'd0, dec_in_valid}, {31'd0, prev_xfer});
      if (prev_xfer) chk("dec_in", {30'd0, dec_in}, {30'd0, prev_data});
      chk("m_valid", {31'd0, m_valid}, {31'd0, fwd_pend});
      if (fwd_pend) begin
        chk("m_data", {31'd0, m_data}, {31'd0, fwd_bit});
        chk("m_last", {31'd0, m_last}, {31'd0, fwd_last});
      end else begin
        chk("m_last_quiet", {31'd0, m_last}, 32'd0);
      end
      if (xfers == TOTAL && prev_xfer) chk("s_ready_drop", {31'd0, s_ready}, 32'd0);
      if (m_valid) mvalid_cnt++;
      if (m_last) mlast_cnt++;
      if (!dec_RSTn) clr_low++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    // decoder: bits trail the input by LAT pairs, then flush once all pairs have arrived
    if (!dec_RSTn) begin
      rx = 0;
      emitted = 0;
      n_act = n_cfg;
    end else if (dec_in_valid) begin
      rx++;
    end
    fwd_pend = 0;
    if (dec_RSTn && emitted < n_act && (rx > emitted + LAT || rx == TOTAL)) begin
      dec_out_valid = 1'b1;
      dec_out = 1'($urandom);
      fwd_pend = (emitted < FRAME_LEN);
      fwd_bit = dec_out;
      fwd_last = (emitted == FRAME_LEN - 1);
      emitted++;
    end else begin
      dec_out_valid = 1'b0;
    end
    // upstream source
    if (feeding) begin
      case (gap_mode)
        0: v = 1'b1;
        1: v = pat5[pidx % 5];
        default: v = (($urandom % 4) != 0);
      endcase
      pidx++;
    end else begin
      v = 1'b0;
    end
    s_valid = v;
    s_data = 2'($urandom);
    prev_xfer = v & s_ready;
    prev_data = s_data;
    if (prev_xfer) begin
      xfers++;
      if (xfers == TOTAL) t_last = cyc;
    end
    start = start_req | (done & poke_done);
    start_req = 0;
  endtask

  task automatic run_frame(input int n, input int gmode, input bit exp_tmo,
                           input bit spur, input int abort_at);
    int budget;
    bit spur_done;
    int exp_m;
    n_cfg = n; gap_mode = gmode; poke_done = spur;
    xfers = 0; mvalid_cnt = 0; mlast_cnt = 0; clr_low = 0; done_cnt = 0; pidx = 0;
    start_req = 1;
    tick();
    feeding = 1;
    tick();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("dec_rstn_clr", {31'd0, dec_RSTn}, 32'd0);
    chk("err_cleared", {31'd0, err_timeout}, 32'd0);
    budget = 0;
    spur_done = 0;
    while (done_cnt == 0 && budget < 5000) begin
      if (spur && !spur_done && xfers >= 100) begin
        start_req = 1;
        spur_done = 1;
      end
      tick();
      budget++;
      if (abort_at > 0 && xfers >= abort_at) break;
    end
    if (abort_at > 0) return;
    chk("err_at_done", {31'd0, err_timeout}, {31'd0, exp_tmo});
    chk("last_at_done", {31'd0, m_last}, {31'd0, !exp_tmo});
    if (exp_tmo) chk("tmo_latency", done_cyc - t_last, TMO + 1);
    exp_frames++;
    feeding = 0;
    tick();
    exp_m = (n < FRAME_LEN) ? n : FRAME_LEN;
    chk("done_once", done_cnt, 1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("frame_cnt", {16'd0, frame_cnt}, exp_frames);
    chk("m_valid_count", mvalid_cnt, exp_m);
    chk("m_last_count", mlast_cnt, exp_tmo ? 0 : 1);
    chk("xfer_count", xfers, TOTAL);
    chk("clr_cycles", clr_low, CLR_CYCLES);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_dec_rstn", {31'd0, dec_RSTn}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_dec_in_valid", {31'd0, dec_in_valid}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    RSTn = 1'b1;
    #1;
    chk("dec_rstn_follows", {31'd0, dec_RSTn}, 32'd1);

    run_frame(628, 0, 1'b0, 1'b1, 0);   // nominal, spurious starts in FEED and DONE
    run_frame(628, 1, 1'b0, 1'b0, 0);   // 1,0,1,1,0 upstream gaps, back-to-back
    run_frame(640, 2, 1'b0, 1'b0, 0);   // surplus decoder output
    run_frame(600, 0, 1'b1, 1'b0, 0);   // decoder stalls -> timeout
    run_frame(628, 2, 1'b0, 1'b0, 0);   // start clears err_timeout

    run_frame(628, 0, 1'b0, 1'b0, 300); // abandoned by reset
    #2 RSTn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_dec_in_valid", {31'd0, dec_in_valid}, 32'd0);
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_dec_rstn", {31'd0, dec_RSTn}, 32'd0);
    chk("arst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("arst_no_done", done_cnt, 0);
    feeding = 0;
    tick();
    tick();
    RSTn = 1'b1;
    exp_frames = 0;
    run_frame(628, 0, 1'b0, 1'b0, 0);   // fresh frame after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame-level sequencer wrapped around viterbi_decoder. Per frame it clears the decoder, then gates FRAME_LEN+TAIL_LEN coded symbol pairs from an upstream valid/ready source into the decoder. It forwards exactly FRAME_LEN decoded bits downstream with a last marker, discards surplus decoder output, and flags a timeout if the decoder stalls.

Parameters:
FRAME_LEN, 628, information bits per frame; also the number of decoded bits forwarded.
TAIL_LEN, 20, tail symbol pairs per frame, sourced from upstream.
CLR_CYCLES, 2, cycles dec_RSTn is held low before each frame.
TIMEOUT, 4096, max cycles spent in DRAIN before abort.
CNT_W, 11, width of the pair and bit counters; must hold FRAME_LEN+TAIL_LEN.

Ports:
clk  in  1  clock
RSTn  in  1  asynchronous active-low reset
start  in  1  frame start request, sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of frame
err_timeout  out  1  sticky; cleared by accepted start
s_valid  in  1  upstream symbol valid
s_ready  out  1  upstream ready
s_data  in  2  upstream coded symbol pair
dec_RSTn  out  1  decoder reset, active-low; equals RSTn & ~clr_q
dec_in_valid  out  1  drives decoder d_in_valid
dec_in  out  2  drives decoder d_in
dec_out_valid  in  1  from decoder d_out_valid
dec_out  in  1  from decoder d_out
m_valid  out  1  decoded bit valid
m_data  out  1  decoded bit
m_last  out  1  high with the FRAME_LEN-th m_valid
frame_cnt  out  16  completed frames (wraps at 2^16, includes timed-out frames)

Behaviour:
- Reset (async): state IDLE. All outputs 0 except dec_RSTn, which follows RSTn. All counters cleared. A reset mid-frame abandons the frame; no done pulse.
- States: IDLE -> CLR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> CLR; clears err_timeout, in_cnt, out_cnt.
- CLR: clr_q=1 for exactly CLR_CYCLES cycles, then -> FEED. The decoder sees reset low for CLR_CYCLES cycles.
- FEED:
  - s_ready=1 combinationally.
  - A transfer occurs on s_valid&s_ready. It registers dec_in<=s_data and dec_in_valid<=1 the next cycle (1-cycle latency); otherwise dec_in_valid<=0 and dec_in holds.
  - Upstream gaps are allowed; the decoder sees matching valid gaps.
  - in_cnt increments per transfer. The transfer with in_cnt==FRAME_LEN+TAIL_LEN-1 -> DRAIN; s_ready drops that next cycle.
- Output forwarding (FEED and DRAIN):
  - On dec_out_valid with out_cnt<FRAME_LEN: m_valid<=1, m_data<=dec_out, out_cnt++, 1-cycle latency.
  - m_last<=1 when out_cnt==FRAME_LEN-1 at that event.
  - dec_out_valid with out_cnt>=FRAME_LEN, or in IDLE/CLR/DONE: discarded, m_valid=0.
- DRAIN:
  - tmo_cnt increments each cycle, cleared on entry.
  - Exit -> DONE on the cycle the last bit is forwarded (out_cnt reaches FRAME_LEN); the final m_valid/m_last coincides with the DONE state.
  - If out_cnt==FRAME_LEN already on entry -> DONE next cycle.
  - If tmo_cnt==TIMEOUT-1 first: err_timeout<=1 -> DONE, no m_last.
- DONE: done=1 for one cycle, frame_cnt++ -> IDLE. start in DONE is ignored.
- start while busy is ignored. No backpressure from downstream (m_valid has no ready).

Test Plan:
- Nominal: start, 648 pairs with s_valid held high, decoder emits 628 bits.
  - Expect dec_RSTn low 2 cycles, 648 dec_in_valid cycles each 1 cycle after handshake.
  - Expect 628 m_valid with m_last only on the 628th, done once, frame_cnt=1, err_timeout=0.
- Upstream gaps: s_valid toggled 1,0,1,1,0 pattern -> dec_in_valid reproduces the pattern delayed 1 cycle; exactly 648 transfers; s_ready=0 after the 648th.
- Surplus output: model emits 640 bits -> only the first 628 forwarded; remaining 12 produce no m_valid; done still pulses.
- Timeout with TIMEOUT=64: model emits 600 bits then stops -> err_timeout=1 64 cycles into DRAIN, done pulses, no m_last; the next start clears err_timeout.
- Async reset mid-FEED: RSTn low at pair 300 -> all outputs 0 immediately, busy=0, no done; a fresh start then completes a full frame normally.
- start asserted during FEED and DONE -> ignored. Two back-to-back frames -> frame_cnt=2, second frame preceded by its own 2-cycle CLR.
